ide_swap_ctrl: RTL and testbench

Synchronous command-tracking controller for the IDE adapter's host↔drive byte-swap datapath. It snoops ATA taskfile writes on the host side, classifies each command, and counts the data-register words of its transfer. It drives a registered SWAP enable so the combinational datapath swaps bytes only during genuine sector data, never during IDENTIFY blocks. It also returns to a known default once each transfer completes.

---
 rtl/ide_swap_ctrl.sv | 134 +++++++++++++
 tb/tb_ide_swap_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ide_swap_ctrl.sv
// ide_swap_ctrl: snoops ATA taskfile traffic and drives a registered byte-swap enable for the datapath
module ide_swap_ctrl #(
  parameter int SYNC_STAGES      = 2,
  parameter bit SWAP_DEFAULT     = 1'b1,
  parameter int WORDS_PER_SECTOR = 256
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       _RESET,
  input  logic [1:0] _CS,
  input  logic [2:0] DA,
  input  logic       _DIOW,
  input  logic       _DIOR,
  input  logic [7:0] D,
  output logic       SWAP,
  output logic [7:0] CMD,
  output logic       BUSY,
  output logic [8:0] SECTLEFT,
  output logic [7:0] WORDCNT,
  output logic       STRAY
);
  typedef enum logic [1:0] {IDLE, ID_XFER, DATA_XFER} state_t;

  // Quiescent bus: _RESET high, both chip selects and strobes deasserted.
  localparam logic [15:0] BUS_IDLE  = 16'hE300;
  localparam logic [7:0]  LAST_WORD = 8'(WORDS_PER_SECTOR - 1);

  logic [SYNC_STAGES-1:0][15:0] sync_q;
  logic [15:0] bus_s;
  logic        diow_prev_q, dior_prev_q;
  logic [1:0]  cs_q;
  logic [2:0]  da_q;
  logic [7:0]  d_q, cmd_q, wordcnt_q;
  logic [8:0]  sc_q, sectleft_q;
  state_t      state_q;
  logic        swap_q, busy_q, stray_q;
  logic        wr_done, rd_done, pri, cmd_wr, sc_wr, data_acc, devctl_wr, bus_rst, is_id, is_rw;

  // Every ATA input, data included, crosses into CLK through the same depth so they stay aligned.
  always_ff @(posedge CLK) begin
    if (RESET) sync_q <= {SYNC_STAGES{BUS_IDLE}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], {_RESET, _CS, DA, _DIOW, _DIOR, D}};
  end

  assign bus_s = sync_q[SYNC_STAGES-1];

  // Hold address/data from the last strobe-low cycle; the host may change them as the strobe rises.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      diow_prev_q <= 1'b1;
      dior_prev_q <= 1'b1;
      cs_q        <= 2'b11;
      da_q        <= 3'd0;
      d_q         <= 8'd0;
    end else begin
      diow_prev_q <= bus_s[9];
      dior_prev_q <= bus_s[8];
      if (!bus_s[9] || !bus_s[8]) begin
        cs_q <= bus_s[14:13];
        da_q <= bus_s[12:10];
      end
      if (!bus_s[9]) d_q <= bus_s[7:0];
    end
  end

  assign wr_done   = bus_s[9] & ~diow_prev_q;
  assign rd_done   = bus_s[8] & ~dior_prev_q;
  assign pri       = cs_q == 2'b10;
  assign cmd_wr    = wr_done & pri & (da_q == 3'd7);
  assign sc_wr     = wr_done & pri & (da_q == 3'd2);
  assign data_acc  = (wr_done | rd_done) & pri & (da_q == 3'd0);
  assign devctl_wr = wr_done & (cs_q == 2'b01) & (da_q == 3'd6);
  assign bus_rst   = ~bus_s[15] | (devctl_wr & d_q[2]);
  assign is_id     = (d_q == 8'hEC) || (d_q == 8'hA1);
  assign is_rw     = d_q inside {8'h20, 8'h21, 8'h24, 8'h29, 8'hC4, 8'h30, 8'h31, 8'h34, 8'h39, 8'hC5};

  // Transfer FSM; SWAP/BUSY are registered alongside the state so the datapath sees clean levels.
  always_ff @(posedge CLK) begin
    if (RESET || bus_rst) begin
      state_q    <= IDLE;
      cmd_q      <= 8'h00;
      sectleft_q <= 9'd0;
      wordcnt_q  <= 8'd0;
      sc_q       <= 9'd1;
      swap_q     <= SWAP_DEFAULT;
      busy_q     <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      stray_q <= 1'b0;
      if (sc_wr) sc_q <= (d_q == 8'd0) ? 9'd256 : {1'b0, d_q};
      if (cmd_wr) begin
        cmd_q     <= d_q;
        wordcnt_q <= 8'd0;
        if (is_id) begin
          state_q    <= ID_XFER;
          sectleft_q <= 9'd1;
          swap_q     <= 1'b0;
          busy_q     <= 1'b1;
        end else if (is_rw) begin
          state_q    <= DATA_XFER;
          sectleft_q <= sc_q;
          swap_q     <= 1'b1;
          busy_q     <= 1'b1;
        end else begin
          state_q    <= IDLE;
          sectleft_q <= 9'd0;
          swap_q     <= SWAP_DEFAULT;
          busy_q     <= 1'b0;
        end
      end else if (data_acc) begin
        if (state_q == IDLE) begin
          stray_q <= 1'b1;
        end else if (wordcnt_q == LAST_WORD) begin
          wordcnt_q  <= 8'd0;
          sectleft_q <= sectleft_q - 9'd1;
          if (sectleft_q == 9'd1) begin
            state_q <= IDLE;
            swap_q  <= SWAP_DEFAULT;
            busy_q  <= 1'b0;
          end
        end else begin
          wordcnt_q <= wordcnt_q + 8'd1;
        end
      end
    end
  end

  assign SWAP     = swap_q;
  assign CMD      = cmd_q;
  assign BUSY     = busy_q;
  assign SECTLEFT = sectleft_q;
  assign WORDCNT  = wordcnt_q;
  assign STRAY    = stray_q;
endmodule

// File: tb/tb_ide_swap_ctrl.sv
// tb_ide_swap_ctrl: directed ATA bus sequences with a scoreboard of expected controller outputs
module tb_ide_swap_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_n_bus = 1'b1;
  logic [1:0] cs_n = 2'b11;
  logic [2:0] da = 3'd0;
  logic       diow_n = 1'b1;
  logic       dior_n = 1'b1;
  logic [7:0] d = 8'd0;
  logic       swap, busy, stray;
  logic [7:0] cmd, wordcnt;
  logic [8:0] sectleft;

  typedef struct {
    string      tag;
    logic       swap;
    logic       busy;
    logic       stray;
    logic [7:0] cmd;
    logic [8:0] sl;
    logic [7:0] wc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic p_swap = 1'b1;
  logic p_busy = 1'b0;

  ide_swap_ctrl dut (
    .CLK(clk), .RESET(rst), ._RESET(rst_n_bus), ._CS(cs_n), .DA(da),
    ._DIOW(diow_n), ._DIOR(dior_n), .D(d),
    .SWAP(swap), .CMD(cmd), .BUSY(busy), .SECTLEFT(sectleft), .WORDCNT(wordcnt), .STRAY(stray)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic sw, input logic bz, input logic [7:0] c,
                         input logic [8:0] sl, input logic [7:0] wc);
    chk({tag, ".swap"}, 16'(swap), 16'(sw));
    chk({tag, ".busy"}, 16'(busy), 16'(bz));
    chk({tag, ".cmd"}, 16'(cmd), 16'(c));
    chk({tag, ".sectleft"}, 16'(sectleft), 16'(sl));
    chk({tag, ".wordcnt"}, 16'(wordcnt), 16'(wc));
  endtask

  // One bus cycle: strobe low 3 CLKs, then expected outputs exactly 3 CLKs after the rising edge.
  task automatic access(input bit wr, input logic [1:0] cs, input logic [2:0] a, input logic [7:0] dv,
                        input string tag, input logic sw, input logic bz, input logic st,
                        input logic [7:0] c, input logic [8:0] sl, input logic [7:0] wc);
    exp_t e;
    @(negedge clk);
    cs_n = cs; da = a; d = dv;
    if (wr) diow_n = 1'b0; else dior_n = 1'b0;
    repeat (3) @(negedge clk);
    diow_n = 1'b1; dior_n = 1'b1; cs_n = 2'b11; d = 8'h5A;
    e.tag = tag; e.swap = sw; e.busy = bz; e.stray = st; e.cmd = c; e.sl = sl; e.wc = wc;
    sb.push_back(e);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, ".early_swap"}, 16'(swap), 16'(p_swap));
    chk({tag, ".early_busy"}, 16'(busy), 16'(p_busy));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(e.tag, e.swap, e.busy, e.cmd, e.sl, e.wc);
    chk({e.tag, ".stray"}, 16'(stray), 16'(e.stray));
    @(posedge clk);
    #1;
    chk({e.tag, ".stray_end"}, 16'(stray), 16'h0);
    p_swap = e.swap; p_busy = e.busy;
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b1, 1'b0, 8'h00, 9'd0, 8'd0);
    chk("reset.stray", 16'(stray), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    access(0, 2'b10, 3'd0, 8'h00, "stray_rd", 1, 0, 1, 8'h00, 9'd0, 8'd0);

    access(1, 2'b10, 3'd7, 8'hEC, "cmd_ec", 0, 1, 0, 8'hEC, 9'd1, 8'd0);
    for (int i = 1; i <= 256; i++)
      access(0, 2'b10, 3'd0, 8'h00, "id_rd", (i < 256) ? 1'b1 - 1'b1 : 1'b1, i < 256, 0,
             8'hEC, (i < 256) ? 9'd1 : 9'd0, 8'(i % 256));

    access(1, 2'b10, 3'd2, 8'h02, "sc2", 1, 0, 0, 8'hEC, 9'd0, 8'd0);
    access(1, 2'b10, 3'd7, 8'h20, "cmd_20", 1, 1, 0, 8'h20, 9'd2, 8'd0);
    for (int i = 1; i <= 512; i++)
      access(0, 2'b10, 3'd0, 8'h00, "rd20", 1, i < 512, 0, 8'h20, 9'(2 - i / 256), 8'(i % 256));

    access(1, 2'b10, 3'd2, 8'h00, "sc0", 1, 0, 0, 8'h20, 9'd0, 8'd0);
    access(1, 2'b10, 3'd7, 8'h30, "cmd_30", 1, 1, 0, 8'h30, 9'd256, 8'd0);
    for (int i = 1; i <= 10; i++)
      access(1, 2'b10, 3'd0, 8'(i), "wr30", 1, 1, 0, 8'h30, 9'd256, 8'(i));
    access(1, 2'b10, 3'd1, 8'h55, "features_wr", 1, 1, 0, 8'h30, 9'd256, 8'd10);
    access(0, 2'b10, 3'd7, 8'h00, "status_rd", 1, 1, 0, 8'h30, 9'd256, 8'd10);
    access(1, 2'b10, 3'd7, 8'hEC, "cmd_ec2", 0, 1, 0, 8'hEC, 9'd1, 8'd0);

    access(1, 2'b10, 3'd2, 8'h03, "sc3", 0, 1, 0, 8'hEC, 9'd1, 8'd0);
    access(1, 2'b10, 3'd7, 8'h24, "cmd_24", 1, 1, 0, 8'h24, 9'd3, 8'd0);
    for (int i = 1; i <= 5; i++)
      access(0, 2'b10, 3'd0, 8'h00, "rd24", 1, 1, 0, 8'h24, 9'd3, 8'(i));
    access(1, 2'b01, 3'd6, 8'h04, "srst", 1, 0, 0, 8'h00, 9'd0, 8'd0);
    access(1, 2'b01, 3'd6, 8'h00, "srst_off", 1, 0, 0, 8'h00, 9'd0, 8'd0);
    access(1, 2'b10, 3'd7, 8'hC5, "cmd_c5", 1, 1, 0, 8'hC5, 9'd1, 8'd0);
    for (int i = 1; i <= 3; i++)
      access(1, 2'b10, 3'd0, 8'h00, "wrc5", 1, 1, 0, 8'hC5, 9'd1, 8'(i));

    @(negedge clk);
    rst_n_bus = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busrst.early_busy", 16'(busy), 16'h1);
    @(posedge clk);
    #1;
    chk_all("busrst", 1'b1, 1'b0, 8'h00, 9'd0, 8'd0);
    @(negedge clk);
    rst_n_bus = 1'b1;
    repeat (4) @(negedge clk);
    p_swap = 1'b1; p_busy = 1'b0;

    access(1, 2'b10, 3'd7, 8'hE7, "cmd_e7", 1, 0, 0, 8'hE7, 9'd0, 8'd0);
    access(1, 2'b10, 3'd2, 8'h04, "sc4", 1, 0, 0, 8'hE7, 9'd0, 8'd0);

    @(negedge clk);
    cs_n = 2'b10; da = 3'd7; d = 8'h20; diow_n = 1'b0;
    repeat (3) @(negedge clk);
    diow_n = 1'b1; cs_n = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_vs_cmd", 1'b1, 1'b0, 8'h00, 9'd0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_all("rst_vs_cmd_after", 1'b1, 1'b0, 8'h00, 9'd0, 8'd0);
    access(1, 2'b10, 3'd7, 8'h21, "cmd_21_sc1", 1, 1, 0, 8'h21, 9'd1, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
